echo_qualifier: RTL and testbench

Sits between the receive beamformer and the time-of-flight/range stage. It takes the aggregated beamformed waveform samples, ignores transmit ringing in a blanking window after each burst, and qualifies echoes with threshold, hysteresis and a minimum-run debounce. It reports the arrival time and peak magnitude of the first qualified echo per ping, or a timeout when no echo arrives.

---
 rtl/echo_qualifier_if.sv | 29 ++
 rtl/echo_qualifier.sv | 175 +++++++++++++++++
 tb/tb_echo_qualifier.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/echo_qualifier_if.sv
// Beamformed sample stream in, echo/peak/timeout reports out.
// The slave side is the qualifier; the master side is the upstream feeder.
interface echo_qualifier_if #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int TIME_WIDTH   = 24
);
    logic                    burst_start_in;
    logic [TIME_WIDTH-1:0]   time_in;
    logic [SAMPLE_WIDTH-1:0] sample_in;
    logic                    sample_valid_in;
    logic                    echo_valid_out;
    logic [TIME_WIDTH-1:0]   echo_time_out;
    logic                    peak_valid_out;
    logic [SAMPLE_WIDTH-2:0] peak_out;
    logic                    echo_active_out;
    logic                    timeout_out;

    modport slave (
        input  burst_start_in, time_in, sample_in, sample_valid_in,
        output echo_valid_out, echo_time_out, peak_valid_out, peak_out,
               echo_active_out, timeout_out
    );

    modport master (
        output burst_start_in, time_in, sample_in, sample_valid_in,
        input  echo_valid_out, echo_time_out, peak_valid_out, peak_out,
               echo_active_out, timeout_out
    );
endinterface

// File: rtl/echo_qualifier.sv
// Per-ping echo detector: blanking, threshold with hysteresis, min-run debounce,
// then reports first-echo arrival time, peak magnitude, or a listen timeout.
module echo_qualifier #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int TIME_WIDTH   = 24,
    parameter int THRESHOLD    = 5000,
    parameter int HYST         = 1000,
    parameter int MIN_RUN      = 4,
    parameter int BLANK_CYCLES = 60000,
    parameter int LISTEN_LIMIT = 16000000
) (
    input  logic             clk_in,
    input  logic             rst_in,
    echo_qualifier_if.slave  bus
);
    localparam int MAG_W = SAMPLE_WIDTH - 1;
    localparam int RUN_W = $clog2(MIN_RUN + 1);
    localparam logic [MAG_W-1:0]      HI_LVL  = MAG_W'(THRESHOLD);
    localparam logic [MAG_W-1:0]      LO_LVL  = MAG_W'(THRESHOLD - HYST);
    localparam logic [TIME_WIDTH-1:0] BLANK_T = TIME_WIDTH'(BLANK_CYCLES);
    localparam logic [TIME_WIDTH-1:0] LIMIT_T = TIME_WIDTH'(LISTEN_LIMIT);
    localparam logic [RUN_W:0]        RUN_MAX = (RUN_W + 1)'(MIN_RUN);

    typedef enum logic [2:0] {IDLE, BLANK, LISTEN, QUALIFY, TRACK, DONE} state_t;

    state_t                  state_q, state_d;
    logic [RUN_W-1:0]        run_q, run_d;
    logic [TIME_WIDTH-1:0]   cand_q, cand_d;
    logic [MAG_W-1:0]        peak_q, peak_d;
    logic [TIME_WIDTH-1:0]   echo_time_q, echo_time_d;
    logic [MAG_W-1:0]        peak_out_q, peak_out_d;
    logic                    echo_valid_q, echo_valid_d;
    logic                    peak_valid_q, peak_valid_d;
    logic                    timeout_q, timeout_d;
    logic                    active_q, active_d;

    logic signed [SAMPLE_WIDTH-1:0] neg;
    logic [MAG_W-1:0]               mag, peak_max;
    logic [RUN_W:0]                 run_inc;
    logic                           hi, lo, at_limit, vld;

    always_comb begin
        neg = -bus.sample_in;
        if (!bus.sample_in[SAMPLE_WIDTH-1])
            mag = bus.sample_in[MAG_W-1:0];
        else if (neg[SAMPLE_WIDTH-1])
            mag = '1;  // only the most negative code is still negative after negation
        else
            mag = neg[MAG_W-1:0];
    end

    assign hi       = mag >= HI_LVL;
    assign lo       = mag < LO_LVL;
    assign peak_max = (mag > peak_q) ? mag : peak_q;
    assign at_limit = bus.time_in >= LIMIT_T;
    assign vld      = bus.sample_valid_in;
    assign run_inc  = {1'b0, run_q} + 1'b1;

    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        cand_d       = cand_q;
        peak_d       = peak_q;
        echo_time_d  = echo_time_q;
        peak_out_d   = peak_out_q;
        echo_valid_d = 1'b0;
        peak_valid_d = 1'b0;
        timeout_d    = 1'b0;
        if (bus.burst_start_in) begin
            state_d     = BLANK;
            run_d       = '0;
            cand_d      = '0;
            peak_d      = '0;
            echo_time_d = '0;
            peak_out_d  = '0;
        end else begin
            case (state_q)
                BLANK: begin
                    if (at_limit) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end else if (bus.time_in >= BLANK_T) begin
                        state_d = LISTEN;
                    end
                end
                LISTEN: begin
                    if (at_limit) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end else if (vld && hi) begin
                        cand_d = bus.time_in;
                        run_d  = RUN_W'(1);
                        peak_d = mag;
                        if (MIN_RUN == 1) begin
                            state_d      = TRACK;
                            echo_valid_d = 1'b1;
                            echo_time_d  = bus.time_in;
                        end else begin
                            state_d = QUALIFY;
                        end
                    end
                end
                QUALIFY: begin
                    if (at_limit) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end else if (vld && lo) begin
                        run_d   = '0;
                        state_d = LISTEN;
                    end else if (vld) begin
                        // mid-band samples keep the run alive: that is the hysteresis
                        peak_d = peak_max;
                        if (run_inc >= RUN_MAX) begin
                            run_d        = RUN_MAX[RUN_W-1:0];
                            state_d      = TRACK;
                            echo_valid_d = 1'b1;
                            echo_time_d  = cand_q;
                        end else begin
                            run_d = run_inc[RUN_W-1:0];
                        end
                    end
                end
                TRACK: begin
                    if (at_limit) begin
                        peak_out_d   = peak_q;
                        peak_valid_d = 1'b1;
                        state_d      = DONE;
                    end else if (vld) begin
                        peak_d = peak_max;
                        if (lo) begin
                            peak_out_d   = peak_max;
                            peak_valid_d = 1'b1;
                            state_d      = DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
        active_d = (state_d == TRACK);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            run_q        <= '0;
            cand_q       <= '0;
            peak_q       <= '0;
            echo_time_q  <= '0;
            peak_out_q   <= '0;
            echo_valid_q <= 1'b0;
            peak_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            cand_q       <= cand_d;
            peak_q       <= peak_d;
            echo_time_q  <= echo_time_d;
            peak_out_q   <= peak_out_d;
            echo_valid_q <= echo_valid_d;
            peak_valid_q <= peak_valid_d;
            timeout_q    <= timeout_d;
            active_q     <= active_d;
        end
    end

    assign bus.echo_valid_out  = echo_valid_q;
    assign bus.echo_time_out   = echo_time_q;
    assign bus.peak_valid_out  = peak_valid_q;
    assign bus.peak_out        = peak_out_q;
    assign bus.echo_active_out = active_q;
    assign bus.timeout_out     = timeout_q;
endmodule

// File: tb/tb_echo_qualifier.sv
// Directed pings against echo_qualifier; a scoreboard queue holds expected
// report pulses (kind, value, time_in at which the pulse is visible).
module tb_echo_qualifier;
    localparam int SW = 16;
    localparam int TW = 24;
    localparam int K_ECHO = 0, K_PEAK = 1, K_TMO = 2;

    typedef struct {
        int kind;
        int val;
        int stamp;
    } ev_t;

    logic clk_in = 1'b0;
    logic rst_in;
    always #5 clk_in = ~clk_in;

    echo_qualifier_if #(.SAMPLE_WIDTH(SW), .TIME_WIDTH(TW)) bus ();

    echo_qualifier #(
        .SAMPLE_WIDTH(SW), .TIME_WIDTH(TW), .THRESHOLD(5000), .HYST(1000),
        .MIN_RUN(3), .BLANK_CYCLES(100), .LISTEN_LIMIT(1000)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus.slave)
    );

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  tcur   = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0d)", name, act, req, tcur);
        end
    endtask

    task automatic expect_ev(input int kind, input int val, input int stamp);
        ev_t e;
        e.kind = kind; e.val = val; e.stamp = stamp;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event kind=%0d actual_time=%0d required=none", kind, bus.time_in);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (e.kind != K_TMO) chk("event_value", val, e.val);
            chk("event_time", int'(bus.time_in), e.stamp);
        end
    endtask

    // Monitor: compares every report pulse against the scoreboard head.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (bus.echo_valid_out) pop_cmp(K_ECHO, int'(bus.echo_time_out));
            if (bus.peak_valid_out) pop_cmp(K_PEAK, int'(bus.peak_out));
            if (bus.timeout_out)    pop_cmp(K_TMO, 0);
        end
    end

    task automatic cyc(input int s, input bit v);
        bus.burst_start_in  = 1'b0;
        bus.time_in         = TW'(tcur);
        bus.sample_in       = SW'(s);
        bus.sample_valid_in = v;
        @(posedge clk_in);
        #1;
        tcur++;
    endtask

    task automatic burst();
        bus.burst_start_in  = 1'b1;
        bus.time_in         = TW'(tcur);
        bus.sample_in       = SW'(20000);   // must be discarded
        bus.sample_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        bus.burst_start_in = 1'b0;
        tcur = 0;
    endtask

    task automatic idle_to(input int t);
        while (tcur < t) cyc(0, 1'b1);
    endtask

    task automatic hi_run(input int s, input int n);
        for (int i = 0; i < n; i++) cyc(s, 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_echo_valid"},  int'(bus.echo_valid_out), 0);
        chk({tag, "_echo_time"},   int'(bus.echo_time_out), 0);
        chk({tag, "_peak_valid"},  int'(bus.peak_valid_out), 0);
        chk({tag, "_peak"},        int'(bus.peak_out), 0);
        chk({tag, "_active"},      int'(bus.echo_active_out), 0);
        chk({tag, "_timeout"},     int'(bus.timeout_out), 0);
    endtask

    task automatic pulse_rst();
        #2 rst_in = 1'b1;
        #1 chk_all_zero("async_rst");
        #2 rst_in = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1;
        bus.burst_start_in = 1'b0;
        bus.time_in = '0;
        bus.sample_in = '0;
        bus.sample_valid_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 chk_all_zero("reset");
        #3 rst_in = 1'b0;

        // Blanking: a loud sample at 50 is ignored; the ping times out
        burst();
        expect_ev(K_TMO, 0, 1001);
        idle_to(50);
        cyc(20000, 1'b1);
        idle_to(1003);
        chk("blank_echo_time", int'(bus.echo_time_out), 0);
        chk("blank_queue", exp_q.size(), 0);

        // Qualified echo with a mid-band third sample
        burst();
        expect_ev(K_ECHO, 200, 203);
        expect_ev(K_PEAK, 7000, 204);
        idle_to(200);
        cyc(6000, 1'b1);
        cyc(-7000, 1'b1);
        cyc(4500, 1'b1);
        chk("qual_active_hi", int'(bus.echo_active_out), 1);
        cyc(0, 1'b1);
        chk("qual_active_lo", int'(bus.echo_active_out), 0);
        idle_to(1003);
        chk("qual_peak_held", int'(bus.peak_out), 7000);
        chk("qual_queue", exp_q.size(), 0);

        // Debounce reject then a real echo at 400
        burst();
        expect_ev(K_ECHO, 400, 403);
        expect_ev(K_PEAK, 6000, 404);
        idle_to(300);
        cyc(6000, 1'b1);
        cyc(6000, 1'b1);
        cyc(3000, 1'b1);
        idle_to(400);
        hi_run(6000, 3);
        cyc(0, 1'b1);
        idle_to(410);
        chk("debounce_queue", exp_q.size(), 0);

        // Saturation of the most negative sample
        burst();
        expect_ev(K_ECHO, 200, 203);
        expect_ev(K_PEAK, 32767, 204);
        idle_to(200);
        cyc(6000, 1'b1);
        cyc(-32768, 1'b1);
        cyc(5000, 1'b1);
        cyc(0, 1'b1);
        idle_to(210);
        chk("sat_queue", exp_q.size(), 0);

        // Re-arm during TRACK, then blank and detect again
        burst();
        expect_ev(K_ECHO, 200, 203);
        idle_to(200);
        hi_run(6000, 5);
        chk("rearm_active_pre", int'(bus.echo_active_out), 1);
        burst();
        chk("rearm_active", int'(bus.echo_active_out), 0);
        chk("rearm_echo_time", int'(bus.echo_time_out), 0);
        chk("rearm_peak", int'(bus.peak_out), 0);
        expect_ev(K_ECHO, 150, 153);
        expect_ev(K_PEAK, 6000, 154);
        idle_to(50);
        hi_run(20000, 3);
        idle_to(150);
        hi_run(6000, 3);
        cyc(0, 1'b1);
        idle_to(160);
        chk("rearm_queue", exp_q.size(), 0);

        // Limit reached in TRACK: peak excludes the limit-cycle sample, no timeout
        burst();
        expect_ev(K_ECHO, 990, 993);
        expect_ev(K_PEAK, 9000, 1001);
        idle_to(990);
        hi_run(6000, 8);
        cyc(9000, 1'b1);
        cyc(6000, 1'b1);
        cyc(30000, 1'b1);
        hi_run(6000, 5);
        chk("limit_active", int'(bus.echo_active_out), 0);
        chk("limit_queue", exp_q.size(), 0);

        // Async reset mid-TRACK clears held outputs without a clock edge
        burst();
        expect_ev(K_ECHO, 200, 203);
        idle_to(200);
        hi_run(6000, 5);
        chk("rst_track_echo_time", int'(bus.echo_time_out), 200);
        pulse_rst();

        // Async reset mid-QUALIFY: block returns to IDLE and ignores the run
        burst();
        idle_to(200);
        hi_run(6000, 2);
        pulse_rst();
        hi_run(6000, 6);
        cyc(0, 1'b1);
        idle_to(1005);
        chk("rst_qual_echo_time", int'(bus.echo_time_out), 0);
        chk("rst_qual_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
